// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and frame helper for the UART transmitter
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } tx_state_e;

  // Bit times in one frame: start + data + optional parity + stop bits.
  function automatic int frame_bits(input int bits, input int parity, input int stop);
    return 1 + bits + ((parity != 0) ? 1 : 0) + stop;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - first-word-fall-through FIFO with registered flags and level
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_cnt;
  logic [AW:0]      r_rd_cnt;
  logic [AW:0]      r_level;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_wr_nxt;
  logic [AW:0]      w_rd_nxt;
  logic [AW:0]      w_level_nxt;

  assign w_push      = push && !r_full;
  assign w_pop       = pop && !r_empty;
  assign w_wr_nxt    = r_wr_cnt + {{AW{1'b0}}, w_push};
  assign w_rd_nxt    = r_rd_cnt + {{AW{1'b0}}, w_pop};
  assign w_level_nxt = w_wr_nxt - w_rd_nxt;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_cnt[AW-1:0]] <= din;
  end

  // A first write into an empty FIFO becomes visible one edge later; a pop to empty is seen at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_wr_cnt <= w_wr_nxt;
      r_rd_cnt <= w_rd_nxt;
      r_level  <= w_level_nxt;
      r_full   <= (w_level_nxt == FULL_LEVEL);
      r_empty  <= (w_level_nxt == '0) || (r_level == '0);
    end
  end

  assign dout  = r_mem[r_rd_cnt[AW-1:0]];
  assign full  = r_full;
  assign empty = r_empty;
  assign level = r_level;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-fed UART transmitter; UART_TX_BREAK_EN adds a send_break input
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 10,
  parameter int BITS_PER_WORD    = 8,
  parameter int FIFO_DEPTH       = 4,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef UART_TX_BREAK_EN
  input  logic                        send_break,
`endif
  input  logic                        s_valid,
  input  logic [BITS_PER_WORD-1:0]    s_data,
  output logic                        s_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int BAUD_W = $clog2(CLOCKS_PER_PULSE);
  localparam int BIT_W  = $clog2(BITS_PER_WORD + 3);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(BITS_PER_WORD - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam parity_e           PAR_MODE  = parity_e'(PARITY[1:0]);

  tx_state_e                r_state, w_state_nxt;
  logic [BAUD_W-1:0]        r_baud, w_baud_nxt;
  logic [BIT_W-1:0]         r_bit, w_bit_nxt;
  logic [BITS_PER_WORD-1:0] r_shift, w_shift_nxt;
  logic                     r_par, w_par_nxt;
  logic                     r_tx, w_tx_nxt;
  logic                     r_busy;
  logic                     w_load, w_pop, w_baud_end, w_par_load, w_brk_req;
  logic                     w_full, w_empty;
  logic [BITS_PER_WORD-1:0] w_fifo_dout;

  uart_sync_fifo #(.WIDTH(BITS_PER_WORD), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid && s_ready),
    .pop   (w_pop),
    .din   (s_data),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

`ifdef UART_TX_BREAK_EN
  localparam logic [BIT_W-1:0] BRK_LOW_LAST = BIT_W'(BITS_PER_WORD + 1);
  localparam logic [BIT_W-1:0] BRK_LAST     = BIT_W'(BITS_PER_WORD + 2);
  logic r_brk_pend;
  assign w_brk_req = send_break || r_brk_pend;
  always_ff @(posedge clk) begin
    if (rst) r_brk_pend <= 1'b0;
    else     r_brk_pend <= w_brk_req && (r_state != S_IDLE);
  end
`else
  assign w_brk_req = 1'b0;
`endif

  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_par_load = (PAR_MODE == PAR_EVEN) ? ^w_fifo_dout : ~^w_fifo_dout;

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = w_baud_end ? '0 : r_baud + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_tx_nxt    = r_tx;
    w_load      = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        w_bit_nxt  = '0;
        w_tx_nxt   = 1'b1;
        if (w_brk_req) begin
          w_state_nxt = S_BREAK;
          w_tx_nxt    = 1'b0;
        end else if (!w_empty) begin
          w_load = 1'b1;
        end
      end
      S_START: if (w_baud_end) begin
        w_state_nxt = S_DATA;
        w_tx_nxt    = r_shift[0];
      end
      S_DATA: if (w_baud_end) begin
        if (r_bit == DATA_LAST) begin
          w_bit_nxt = '0;
          if (PAR_MODE != PAR_NONE) begin
            w_state_nxt = S_PARITY;
            w_tx_nxt    = r_par;
          end else begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_bit_nxt   = r_bit + 1'b1;
          w_shift_nxt = r_shift >> 1;
          w_tx_nxt    = r_shift[1];
        end
      end
      S_PARITY: if (w_baud_end) begin
        w_state_nxt = S_STOP;
        w_tx_nxt    = 1'b1;
      end
      S_STOP: if (w_baud_end) begin
        if (r_bit == STOP_LAST) begin
          w_bit_nxt = '0;
          if (!w_empty && !w_brk_req) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_bit_nxt = r_bit + 1'b1;
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: if (w_baud_end) begin
        if (r_bit == BRK_LAST) begin
          w_state_nxt = S_IDLE;
          w_bit_nxt   = '0;
          w_tx_nxt    = 1'b1;
        end else begin
          w_bit_nxt = r_bit + 1'b1;
          if (r_bit == BRK_LOW_LAST) w_tx_nxt = 1'b1;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
    // Popping the next word lands directly in START, so back-to-back frames have no idle gap.
    if (w_load) begin
      w_pop       = 1'b1;
      w_shift_nxt = w_fifo_dout;
      w_par_nxt   = w_par_load;
      w_tx_nxt    = 1'b0;
      w_state_nxt = S_START;
      w_baud_nxt  = '0;
      w_bit_nxt   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign s_ready = !w_full;
  assign tx      = r_tx;
  assign busy    = r_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed bench for uart_tx_fifo across 8N1, 8E1, 8O1 and 5N2 builds
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] r_valid = '0;
  logic [7:0] r_data = '0;
  logic [3:0] r_brk = '0;
  logic [3:0] w_tx, w_busy, w_rdy;
  logic [2:0] w_lvl [4];

  int n_total = 0;
  int n_bad   = 0;

  logic [3:0][15:0] fr;
  logic [3:0][3:0]  nb;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLOCKS_PER_PULSE(4), .BITS_PER_WORD(8), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst),
`ifdef UART_TX_BREAK_EN
    .send_break(r_brk[0]),
`endif
    .s_valid(r_valid[0]), .s_data(r_data), .s_ready(w_rdy[0]), .tx(w_tx[0]), .busy(w_busy[0]), .fifo_level(w_lvl[0]));

  uart_tx_fifo #(.CLOCKS_PER_PULSE(4), .BITS_PER_WORD(8), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst),
`ifdef UART_TX_BREAK_EN
    .send_break(r_brk[1]),
`endif
    .s_valid(r_valid[1]), .s_data(r_data), .s_ready(w_rdy[1]), .tx(w_tx[1]), .busy(w_busy[1]), .fifo_level(w_lvl[1]));

  uart_tx_fifo #(.CLOCKS_PER_PULSE(4), .BITS_PER_WORD(8), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst),
`ifdef UART_TX_BREAK_EN
    .send_break(r_brk[2]),
`endif
    .s_valid(r_valid[2]), .s_data(r_data), .s_ready(w_rdy[2]), .tx(w_tx[2]), .busy(w_busy[2]), .fifo_level(w_lvl[2]));

  uart_tx_fifo #(.CLOCKS_PER_PULSE(4), .BITS_PER_WORD(5), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(2)) u_5n2 (
    .clk(clk), .rst(rst),
`ifdef UART_TX_BREAK_EN
    .send_break(r_brk[3]),
`endif
    .s_valid(r_valid[3]), .s_data(r_data[4:0]), .s_ready(w_rdy[3]), .tx(w_tx[3]), .busy(w_busy[3]), .fifo_level(w_lvl[3]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one word into each selected instance and walk the frames held in fr/nb cycle by cycle.
  task automatic send_check(input logic [3:0] act, input logic [7:0] d);
    r_data  = d;
    r_valid = act;
    tick();
    r_valid = '0;
    for (int j = 0; j < 4; j++) if (act[j]) begin
      check_eq($sformatf("lat0_tx%0d", j), {31'b0, w_tx[j]}, 1);
      check_eq($sformatf("lat0_busy%0d", j), {31'b0, w_busy[j]}, 0);
      check_eq($sformatf("lat0_lvl%0d", j), {29'b0, w_lvl[j]}, 1);
    end
    tick();
    for (int j = 0; j < 4; j++) if (act[j])
      check_eq($sformatf("lat1_tx%0d", j), {31'b0, w_tx[j]}, 1);
    tick();
    for (int c = 0; c < 48; c++) begin
      for (int j = 0; j < 4; j++) if (act[j]) begin
        if (c < int'(nb[j]) * 4) begin
          check_eq($sformatf("tx%0d_c%0d", j, c), {31'b0, w_tx[j]}, {31'b0, fr[j][c/4]});
          check_eq($sformatf("busy%0d_c%0d", j, c), {31'b0, w_busy[j]}, 1);
        end else begin
          check_eq($sformatf("idle_tx%0d_c%0d", j, c), {31'b0, w_tx[j]}, 1);
          check_eq($sformatf("idle_busy%0d_c%0d", j, c), {31'b0, w_busy[j]}, 0);
        end
      end
      tick();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    for (int j = 0; j < 4; j++) begin
      check_eq($sformatf("rst_tx%0d", j), {31'b0, w_tx[j]}, 1);
      check_eq($sformatf("rst_rdy%0d", j), {31'b0, w_rdy[j]}, 1);
      check_eq($sformatf("rst_busy%0d", j), {31'b0, w_busy[j]}, 0);
      check_eq($sformatf("rst_lvl%0d", j), {29'b0, w_lvl[j]}, 0);
    end
    rst = 1'b0;
    tick();

    // 0xA5: 8N1, even parity bit 0, odd parity bit 1
    fr[0] = {6'b0, 1'b1, 8'hA5, 1'b0};       nb[0] = 4'd10;
    fr[1] = {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}; nb[1] = 4'd11;
    fr[2] = {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}; nb[2] = 4'd11;
    send_check(4'b0111, 8'hA5);

    // 0x07: even parity bit 1, odd parity bit 0
    fr[0] = {6'b0, 1'b1, 8'h07, 1'b0};       nb[0] = 4'd10;
    fr[1] = {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}; nb[1] = 4'd11;
    fr[2] = {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}; nb[2] = 4'd11;
    send_check(4'b0111, 8'h07);

    // 5 data bits, 2 stop bits: 8 bit times, last two high
    fr[3] = {8'b0, 2'b11, 5'h1F, 1'b0}; nb[3] = 4'd8;
    send_check(4'b1000, 8'h1F);

    // Hold s_valid with 0x01..0x06 into a depth-4 FIFO
    fork
      begin : feed
        int  idx;
        logic rdy;
        idx = 0;
        for (int t = 0; t < 400 && idx < 6; t++) begin
          r_valid[0] = 1'b1;
          r_data     = 8'(idx + 1);
          rdy        = w_rdy[0];
          tick();
          if (rdy) begin
            idx++;
            if (idx == 5) begin
              check_eq("fill_level", {29'b0, w_lvl[0]}, 4);
              check_eq("fill_ready", {31'b0, w_rdy[0]}, 0);
            end
          end
        end
        r_valid[0] = 1'b0;
        check_eq("fill_accepts", idx, 6);
      end
      begin : mon
        int t;
        logic [7:0] b;
        t = 0;
        while (w_tx[0] !== 1'b0 && t < 20) begin
          tick();
          t++;
        end
        check_eq("fill_first_start", {31'b0, w_tx[0]}, 0);
        for (int f = 0; f < 6; f++) begin
          b = '0;
          for (int c = 0; c < 40; c++) begin
            if (c == 0) check_eq($sformatf("b2b_start%0d", f), {31'b0, w_tx[0]}, 0);
            if (c >= 4 && c < 36 && (c % 4) == 2) b[(c-4)/4] = w_tx[0];
            if (c == 39) check_eq($sformatf("b2b_stop%0d", f), {31'b0, w_tx[0]}, 1);
            tick();
          end
          check_eq($sformatf("fill_word%0d", f), {24'b0, b}, f + 1);
        end
      end
    join
    repeat (4) tick();
    check_eq("fill_done_busy", {31'b0, w_busy[0]}, 0);

`ifdef UART_TX_BREAK_EN
    begin
      int cnt;
      logic [7:0] b;
      r_data = 8'h3C; r_valid[0] = 1'b1; tick();
      r_data = 8'h5A; tick();
      r_valid[0] = 1'b0;
      repeat (4) tick();
      r_brk[0] = 1'b1; tick(); r_brk[0] = 1'b0;
      cnt = 0;
      while (w_busy[0] !== 1'b0 && cnt < 100) begin tick(); cnt++; end
      check_eq("brk_gap_busy", {31'b0, w_busy[0]}, 0);
      tick();
      cnt = 0;
      while (w_tx[0] === 1'b0 && cnt < 100) begin tick(); cnt++; end
      check_eq("brk_low_len", cnt, 40);
      cnt = 0;
      while (w_tx[0] === 1'b1 && cnt < 100) begin tick(); cnt++; end
      check_eq("brk_high_len", cnt, 5);
      repeat (6) tick();
      for (int i = 0; i < 8; i++) begin
        b[i] = w_tx[0];
        repeat (4) tick();
      end
      check_eq("brk_after_word", {24'b0, b}, 8'h5A);
      repeat (12) tick();
    end
`endif

    // Reset mid-DATA with three words queued
    for (int i = 0; i < 4; i++) begin
      r_valid[0] = 1'b1;
      r_data     = 8'h11 + 8'(i);
      tick();
    end
    r_valid[0] = 1'b0;
    repeat (6) tick();
    check_eq("pre_rst_lvl", {29'b0, w_lvl[0]}, 3);
    check_eq("pre_rst_busy", {31'b0, w_busy[0]}, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_tx", {31'b0, w_tx[0]}, 1);
    check_eq("mid_rst_lvl", {29'b0, w_lvl[0]}, 0);
    check_eq("mid_rst_busy", {31'b0, w_busy[0]}, 0);
    check_eq("mid_rst_rdy", {31'b0, w_rdy[0]}, 1);
    begin
      int lows;
      lows = 0;
      for (int c = 0; c < 80; c++) begin
        tick();
        if (w_tx[0] !== 1'b1 || w_busy[0] !== 1'b0) lows++;
      end
      check_eq("post_rst_quiet", lows, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
